// File: rtl/gate_matvec_act.sv
// gate_matvec_act: LSTM/RNN gate engine computing act(Wx*x + Wy*y + b) for all
// HIDDEN_SZ rows in parallel. Weight columns stream in one per cycle from two
// external RAMs; products are scaled by 2^-QM and summed in ACC_W-bit wrapping
// accumulators. After the bias add, the sum saturates to Q(QN.QM), and then a
// run-time selected activation is applied.
//
// Ports:
//   clock, reset     clock; synchronous active-high reset
//   start            one-cycle request, accepted in IDLE or DONE
//   act_sel          00 identity, 01 hard-sigmoid, 10 hard-tanh, 11 ReLU (latched on start)
//   x_in, y_in       vector element read back one cycle after col_addr_x / col_addr_y
//   w_x_col, w_y_col weight column, row r at [r*BITWIDTH +: BITWIDTH], one-cycle latency
//   bias             bias vector, sampled in BIAS
//   col_addr_x/_y    column read addresses
//   busy             high while a computation is in flight
//   data_ready       one-cycle pulse when gate_out is valid
//   gate_out         activated result, held until overwritten or reset
//   sat_flags        (SAT_STATUS_EN only) per-row saturation flags, valid with data_ready
//
// Optional feature macro: SAT_STATUS_EN
module gate_matvec_act #(
    parameter int INPUT_SZ  = 2,
    parameter int HIDDEN_SZ = 16,
    parameter int QN        = 6,
    parameter int QM        = 11,
    parameter int GUARD     = 6,
    localparam int BITWIDTH = QN + QM + 1,
    localparam int ACC_W    = BITWIDTH + GUARD,
    localparam int AX_W     = (INPUT_SZ  > 1) ? $clog2(INPUT_SZ)  : 1,
    localparam int AY_W     = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    act_sel,
    input  logic [BITWIDTH-1:0]           x_in,
    input  logic [BITWIDTH-1:0]           y_in,
    input  logic [HIDDEN_SZ*BITWIDTH-1:0] w_x_col,
    input  logic [HIDDEN_SZ*BITWIDTH-1:0] w_y_col,
    input  logic [HIDDEN_SZ*BITWIDTH-1:0] bias,
    output logic [AX_W-1:0]               col_addr_x,
    output logic [AY_W-1:0]               col_addr_y,
    output logic                          busy,
    output logic                          data_ready,
    output logic [HIDDEN_SZ*BITWIDTH-1:0] gate_out
`ifdef SAT_STATUS_EN
    ,
    output logic [HIDDEN_SZ-1:0]          sat_flags
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN_X, S_RUN_Y, S_DRAIN, S_BIAS, S_ACT, S_DONE
    } state_t;

    // Which scalar/weight pair is arriving from the RAMs this cycle.
    typedef enum logic [1:0] {PH_NONE, PH_X, PH_Y} phase_t;

    localparam logic [AX_W-1:0] X_LAST = AX_W'(INPUT_SZ - 1);
    localparam logic [AY_W-1:0] Y_LAST = AY_W'(HIDDEN_SZ - 1);

    localparam logic signed [BITWIDTH:0] ONE     = (BITWIDTH+1)'(1 << QM);
    localparam logic signed [BITWIDTH:0] NEG_ONE = -ONE;
    localparam logic signed [BITWIDTH:0] HALF    = (BITWIDTH+1)'(1 << (QM - 1));

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [AX_W-1:0] addr_x_q, addr_x_d;
    logic [AY_W-1:0] addr_y_q, addr_y_d;
    logic [1:0]      act_q, act_d;
    logic            start_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_NONE;
            addr_x_q <= '0;
            addr_y_q <= '0;
            act_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            addr_x_q <= addr_x_d;
            addr_y_q <= addr_y_d;
            act_q    <= act_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = PH_NONE;
        addr_x_d = addr_x_q;
        addr_y_d = addr_y_q;
        act_d    = act_q;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d  = S_IDLE;
                addr_x_d = '0;
                addr_y_d = '0;
                if (start) begin
                    start_ok = 1'b1;
                    act_d    = act_sel;
                    state_d  = S_RUN_X;
                end
            end
            S_RUN_X: begin
                phase_d = PH_X;
                if (addr_x_q == X_LAST) state_d = S_RUN_Y;
                else addr_x_d = addr_x_q + AX_W'(1);
            end
            S_RUN_Y: begin
                phase_d = PH_Y;
                if (addr_y_q == Y_LAST) state_d = S_DRAIN;
                else addr_y_d = addr_y_q + AY_W'(1);
            end
            S_DRAIN: state_d = S_BIAS;
            S_BIAS:  state_d = S_ACT;
            S_ACT:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign col_addr_x = addr_x_q;
    assign col_addr_y = addr_y_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign data_ready = (state_q == S_DONE);

    for (genvar r = 0; r < HIDDEN_SZ; r++) begin : g_row
        logic signed [ACC_W-1:0]      acc_q;
        logic signed [BITWIDTH-1:0]   pre_q, pre_d;
        logic        [BITWIDTH-1:0]   gate_q, act_v;
        logic signed [BITWIDTH-1:0]   w_s, s_s;
        logic signed [2*BITWIDTH-1:0] prod;
        logic signed [ACC_W-1:0]      contrib;
        logic signed [ACC_W:0]        sum;
        logic signed [BITWIDTH:0]     pre_e, hsig;
        logic                         ovf;

        always_comb begin
            w_s = (phase_q == PH_X) ? signed'(w_x_col[r*BITWIDTH +: BITWIDTH])
                                    : signed'(w_y_col[r*BITWIDTH +: BITWIDTH]);
            s_s = (phase_q == PH_X) ? signed'(x_in) : signed'(y_in);
            prod    = w_s * s_s;
            contrib = ACC_W'(prod >>> QM);

            // One extra bit so the bias add itself cannot wrap before saturation.
            sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(signed'(bias[r*BITWIDTH +: BITWIDTH]));
            ovf   = (sum[ACC_W:BITWIDTH-1] != {(ACC_W-BITWIDTH+2){sum[ACC_W]}});
            pre_d = ovf ? (sum[ACC_W] ? {1'b1, {(BITWIDTH-1){1'b0}}}
                                      : {1'b0, {(BITWIDTH-1){1'b1}}})
                        : sum[BITWIDTH-1:0];

            pre_e = (BITWIDTH+1)'(pre_q);
            hsig  = (pre_e >>> 2) + HALF;
            act_v = pre_q;
            case (act_q)
                2'b01: begin
                    if (hsig < 0)        act_v = '0;
                    else if (hsig > ONE) act_v = BITWIDTH'(ONE);
                    else                 act_v = hsig[BITWIDTH-1:0];
                end
                2'b10: begin
                    if (pre_e > ONE)          act_v = BITWIDTH'(ONE);
                    else if (pre_e < NEG_ONE) act_v = BITWIDTH'(NEG_ONE);
                end
                2'b11: if (pre_q[BITWIDTH-1]) act_v = '0;
                default: act_v = pre_q;
            endcase
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                acc_q  <= '0;
                pre_q  <= '0;
                gate_q <= '0;
            end else begin
                if (start_ok)                acc_q <= '0;
                else if (phase_q != PH_NONE) acc_q <= acc_q + contrib;
                if (state_q == S_BIAS) pre_q  <= pre_d;
                if (state_q == S_ACT)  gate_q <= act_v;
            end
        end

        assign gate_out[r*BITWIDTH +: BITWIDTH] = gate_q;

`ifdef SAT_STATUS_EN
        logic sat_q;
        always_ff @(posedge clock) begin
            if (reset || start_ok)      sat_q <= 1'b0;
            else if (state_q == S_BIAS) sat_q <= ovf;
        end
        assign sat_flags[r] = sat_q;
`endif
    end

endmodule

// File: tb/tb_gate_matvec_act.sv
module tb_gate_matvec_act;
    localparam int IN  = 2;
    localparam int HID = 16;
    localparam int BW  = 18;
    localparam int LAT = IN + HID + 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset, start;
    logic [1:0]      act_sel;
    logic [BW-1:0]   x_in, y_in;
    logic [HID*BW-1:0] w_x_col, w_y_col, bias, gate_out;
    logic [0:0]      col_addr_x;
    logic [3:0]      col_addr_y;
    logic            busy, data_ready;
`ifdef SAT_STATUS_EN
    logic [HID-1:0]  sat_flags;
`endif

    gate_matvec_act #(
        .INPUT_SZ(IN), .HIDDEN_SZ(HID), .QN(6), .QM(11), .GUARD(6)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .act_sel(act_sel),
        .x_in(x_in), .y_in(y_in), .w_x_col(w_x_col), .w_y_col(w_y_col), .bias(bias),
        .col_addr_x(col_addr_x), .col_addr_y(col_addr_y), .busy(busy),
        .data_ready(data_ready), .gate_out(gate_out)
`ifdef SAT_STATUS_EN
        , .sat_flags(sat_flags)
`endif
    );

    int xv[IN];
    int yv[HID];
    int wxv[IN][HID];
    int wyv[HID][HID];
    int bv[HID];
    int run_act;
    int exp_out[HID];
    bit exp_sat[HID];
    int checks = 0;
    int failures = 0;

    // Weight/vector RAMs with one-cycle read latency.
    always @(posedge clock) begin
        x_in <= BW'(xv[col_addr_x]);
        y_in <= BW'(yv[col_addr_y]);
        for (int r = 0; r < HID; r++) begin
            w_x_col[r*BW +: BW] <= BW'(wxv[col_addr_x][r]);
            w_y_col[r*BW +: BW] <= BW'(wyv[col_addr_y][r]);
        end
    end

    function automatic int rnd18();
        return int'($urandom_range(262143, 0)) - 131072;
    endfunction

    function automatic longint wrap24(input longint v);
        longint m;
        m = v & longint'(24'hFFFFFF);
        if (m >= (longint'(1) << 23)) m = m - (longint'(1) << 24);
        return m;
    endfunction

    task automatic load_bias();
        for (int r = 0; r < HID; r++) bias[r*BW +: BW] = BW'(bv[r]);
    endtask

    task automatic fill(input int xval, input int yval, input int wx, input int wy, input int b);
        for (int c = 0; c < IN; c++) begin
            xv[c] = xval;
            for (int r = 0; r < HID; r++) wxv[c][r] = wx;
        end
        for (int c = 0; c < HID; c++) begin
            yv[c] = yval;
            for (int r = 0; r < HID; r++) wyv[c][r] = wy;
        end
        for (int r = 0; r < HID; r++) bv[r] = b;
        load_bias();
    endtask

    task automatic fill_random();
        for (int c = 0; c < IN; c++) begin
            xv[c] = rnd18();
            for (int r = 0; r < HID; r++) wxv[c][r] = rnd18();
        end
        for (int c = 0; c < HID; c++) begin
            yv[c] = rnd18();
            for (int r = 0; r < HID; r++) wyv[c][r] = rnd18();
        end
        for (int r = 0; r < HID; r++) bv[r] = rnd18();
        load_bias();
    endtask

    // Reference: plain integer dot products, fixed-point scaling by floor division
    // by 2^11, 24-bit wrapping sum, then saturation and activation.
    task automatic compute_expected();
        longint acc, pre, v;
        for (int r = 0; r < HID; r++) begin
            acc = 0;
            for (int c = 0; c < IN; c++)
                acc = wrap24(acc + wrap24((longint'(wxv[c][r]) * longint'(xv[c])) >>> 11));
            for (int c = 0; c < HID; c++)
                acc = wrap24(acc + wrap24((longint'(wyv[c][r]) * longint'(yv[c])) >>> 11));
            pre = acc + longint'(bv[r]);
            exp_sat[r] = 1'b0;
            if (pre > 131071)       begin pre = 131071;  exp_sat[r] = 1'b1; end
            else if (pre < -131072) begin pre = -131072; exp_sat[r] = 1'b1; end
            case (run_act)
                1: begin
                    v = (pre >>> 2) + 1024;
                    if (v < 0) v = 0;
                    if (v > 2048) v = 2048;
                end
                2: v = (pre > 2048) ? 2048 : ((pre < -2048) ? -2048 : pre);
                3: v = (pre < 0) ? 0 : pre;
                default: v = pre;
            endcase
            exp_out[r] = int'(v);
        end
    endtask

    // Pulse start (caller is at a negedge), then watch up to 40 cycles.
    // Returns the cycle data_ready was seen (-1 if never) and busy-profile errors.
    task automatic do_run(input int ign_cyc, output int dr_cyc, output int busy_err);
        start = 1'b1;
        act_sel = 2'(run_act);
        @(posedge clock);
        #1 start = 1'b0;
        dr_cyc = -1;
        busy_err = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (cyc == ign_cyc) begin
                start = 1'b1;
                act_sel = ~act_sel;
            end else begin
                start = 1'b0;
            end
            if (busy !== (cyc < LAT)) busy_err++;
            if (data_ready === 1'b1) begin
                dr_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        act_sel = 2'b00;
        fill(0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || data_ready !== 1'b0 || gate_out !== '0 ||
            col_addr_x !== '0 || col_addr_y !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%b dr=%b gate_out=%h ax=%0d ay=%0d required all zero",
                     busy, data_ready, gate_out, col_addr_x, col_addr_y);
        end
        start = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_over_start busy=%b required 0", busy);
        end
    endtask

    task automatic test_case1();
        int dr, be;
        @(negedge clock);
        fill(2048, 0, 2048, 0, 0);
        run_act = 0;
        do_run(0, dr, be);
        checks++;
        if (dr !== LAT) begin
            failures++;
            $display("FAIL case1_latency got=%0d required=%0d", dr, LAT);
        end
        checks++;
        if (be !== 0) begin
            failures++;
            $display("FAIL case1_busy errors=%0d required=0", be);
        end
        for (int r = 0; r < HID; r++) begin
            checks++;
            if (gate_out[r*BW +: BW] !== 18'd4096) begin
                failures++;
                $display("FAIL case1_row%0d got=%0d required=4096", r, $signed(gate_out[r*BW +: BW]));
            end
        end
        @(negedge clock);
        checks++;
        if (data_ready !== 1'b0 || gate_out[BW-1:0] !== 18'd4096) begin
            failures++;
            $display("FAIL case1_pulse dr=%b row0=%0d required dr=0 row0=4096",
                     data_ready, $signed(gate_out[BW-1:0]));
        end
    endtask

    task automatic test_activations();
        int dr, be;
        int pres[3][3];
        pres = '{'{0, 8192, -8192}, '{1024, 6144, -6144}, '{-1024, 1024, 0}};
        for (int a = 1; a <= 3; a++) begin
            @(negedge clock);
            fill_random();
            for (int c = 0; c < IN; c++) xv[c] = 0;
            for (int c = 0; c < HID; c++) yv[c] = 0;
            for (int k = 0; k < 3; k++) bv[k] = pres[a-1][k];
            load_bias();
            run_act = a;
            compute_expected();
            do_run(0, dr, be);
            checks++;
            if (dr !== LAT) begin
                failures++;
                $display("FAIL act%0d_latency got=%0d required=%0d", a, dr, LAT);
            end
            for (int r = 0; r < HID; r++) begin
                checks++;
                if (gate_out[r*BW +: BW] !== BW'(exp_out[r])) begin
                    failures++;
                    $display("FAIL act%0d_row%0d got=%0d required=%0d", a, r,
                             $signed(gate_out[r*BW +: BW]), exp_out[r]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int dr, be;
        int wy;
        for (int s = 0; s < 2; s++) begin
            wy = (s == 0) ? 63488 : -63488;
            @(negedge clock);
            fill(0, 8192, 0, wy, 0);
            run_act = 0;
            do_run(0, dr, be);
            for (int r = 0; r < HID; r++) begin
                checks++;
                if (gate_out[r*BW +: BW] !== ((s == 0) ? 18'h1FFFF : 18'h20000)) begin
                    failures++;
                    $display("FAIL sat%0d_row%0d got=%0d required=%0d", s, r,
                             $signed(gate_out[r*BW +: BW]), (s == 0) ? 131071 : -131072);
                end
            end
`ifdef SAT_STATUS_EN
            checks++;
            if (sat_flags !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat%0d_flags got=%h required=ffff", s, sat_flags);
            end
`endif
        end
    endtask

    task automatic test_reset_midrun();
        int dr, be, seen;
        @(negedge clock);
        fill(2048, 0, 2048, 0, 0);
        run_act = 0;
        start = 1'b1;
        act_sel = 2'b00;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || gate_out !== '0) begin
            failures++;
            $display("FAIL midrun_reset busy=%b gate_out=%h required busy=0 gate_out=0", busy, gate_out);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (data_ready === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midrun_no_ready pulses=%0d required=0", seen);
        end
        do_run(0, dr, be);
        checks++;
        if (dr !== LAT || gate_out[5*BW +: BW] !== 18'd4096) begin
            failures++;
            $display("FAIL midrun_restart latency=%0d row5=%0d required latency=%0d row5=4096",
                     dr, $signed(gate_out[5*BW +: BW]), LAT);
        end
    endtask

    task automatic test_back_to_back();
        int dr, be;
        @(negedge clock);
        fill_random();
        run_act = 2;
        compute_expected();
        do_run(5, dr, be);
        checks++;
        if (dr !== LAT || be !== 0) begin
            failures++;
            $display("FAIL b2b_first latency=%0d busy_err=%0d required latency=%0d busy_err=0", dr, be, LAT);
        end
        for (int r = 0; r < HID; r++) begin
            checks++;
            if (gate_out[r*BW +: BW] !== BW'(exp_out[r])) begin
                failures++;
                $display("FAIL b2b_first_row%0d got=%0d required=%0d", r,
                         $signed(gate_out[r*BW +: BW]), exp_out[r]);
            end
        end
        // Restart in the data_ready cycle with new data and activation.
        fill_random();
        run_act = 3;
        compute_expected();
        do_run(0, dr, be);
        checks++;
        if (dr !== LAT) begin
            failures++;
            $display("FAIL b2b_second latency=%0d required=%0d", dr, LAT);
        end
        for (int r = 0; r < HID; r++) begin
            checks++;
            if (gate_out[r*BW +: BW] !== BW'(exp_out[r])) begin
                failures++;
                $display("FAIL b2b_second_row%0d got=%0d required=%0d", r,
                         $signed(gate_out[r*BW +: BW]), exp_out[r]);
            end
        end
    endtask

    task automatic test_random();
        int dr, be;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            fill_random();
            run_act = int'($urandom_range(3, 0));
            compute_expected();
            do_run(0, dr, be);
            checks++;
            if (dr !== LAT) begin
                failures++;
                $display("FAIL rand%0d_latency got=%0d required=%0d", n, dr, LAT);
            end
            for (int r = 0; r < HID; r++) begin
                checks++;
                if (gate_out[r*BW +: BW] !== BW'(exp_out[r])) begin
                    failures++;
                    $display("FAIL rand%0d_row%0d act=%0d got=%0d required=%0d", n, r, run_act,
                             $signed(gate_out[r*BW +: BW]), exp_out[r]);
                end
`ifdef SAT_STATUS_EN
                checks++;
                if (sat_flags[r] !== exp_sat[r]) begin
                    failures++;
                    $display("FAIL rand%0d_sat%0d got=%b required=%b", n, r, sat_flags[r], exp_sat[r]);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_case1();
        test_activations();
        test_saturation();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
